// File: rtl/seq_restoring_divider.sv
//------------------------------------------------------------------------------
// seq_restoring_divider
//
// Sequential unsigned restoring divider. Each RUN cycle produces one quotient
// bit, MSB first, so an operation takes DVD_W cycles. Control uses a
// start/busy/done handshake. This is the inverse of the 4x4 array multiplier:
// quotient*divisor + remainder == dividend.
//
// Parameters:
//   DVD_W  dividend/quotient width and number of iteration cycles (>= 2)
//   DVR_W  divisor/remainder width (must be <= DVD_W)
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   start        in   operation request, sampled when busy=0
//   dividend     in   DVD_W-bit unsigned dividend, captured with start
//   divisor      in   DVR_W-bit unsigned divisor, captured with start
//   busy         out  high while iterating
//   done         out  one-cycle pulse; results are valid from this cycle
//   quotient     out  registered quotient, held until the next accepted start
//   remainder    out  registered remainder, held until the next accepted start
//   div_by_zero  out  set alongside done when the captured divisor was zero
//------------------------------------------------------------------------------
module seq_restoring_divider #(
   parameter int DVD_W = 8,
   parameter int DVR_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [DVD_W-1:0] dividend,
   input  logic [DVR_W-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [DVD_W-1:0] quotient,
   output logic [DVR_W-1:0] remainder,
   output logic             div_by_zero
);

   localparam int               CNT_W    = (DVD_W > 1) ? $clog2(DVD_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DVD_W - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_next;

   logic [DVR_W:0]   r_p;        // partial remainder, one guard bit
   logic [DVD_W-1:0] r_q;        // dividend shifting out / quotient shifting in
   logic [CNT_W-1:0] r_cnt;      // bits left to produce, minus one
   logic [DVR_W-1:0] r_dvr;      // captured divisor
   logic [DVD_W-1:0] r_quot;
   logic [DVR_W-1:0] r_rem;
   logic             r_dbz;

   logic             w_accept;
   logic             w_dvr_zero;
   logic             w_last;
   logic [DVR_W:0]   w_t;
   logic             w_ge;
   logic [DVR_W:0]   w_p_new;
   logic [DVD_W-1:0] w_q_new;

   assign w_dvr_zero = (divisor == '0);
   assign w_last     = (r_cnt == '0);

   // Trial subtraction: shift the next dividend bit into the partial
   // remainder and subtract the divisor only if it fits (restoring step).
   assign w_t     = {r_p[DVR_W-1:0], r_q[DVD_W-1]};
   assign w_ge    = (w_t >= {1'b0, r_dvr});
   assign w_p_new = w_ge ? (w_t - {1'b0, r_dvr}) : w_t;
   assign w_q_new = {r_q[DVD_W-2:0], w_ge};

   //---------------------------------------------------------------------------
   // FSM: state register
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   //---------------------------------------------------------------------------
   // FSM: next state and start acceptance. DONE accepts start exactly like
   // IDLE so operations can run back to back with no idle gap.
   //---------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            w_state_next = S_IDLE;
            if (start) begin
               w_accept     = 1'b1;
               w_state_next = w_dvr_zero ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (w_last) begin
               w_state_next = S_DONE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   //---------------------------------------------------------------------------
   // Datapath. Result registers change only on a divide-by-zero accept or at
   // the end of the final RUN cycle, so they hold the previous result while a
   // new operation is iterating.
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_p    <= '0;
         r_q    <= '0;
         r_cnt  <= '0;
         r_dvr  <= '0;
         r_quot <= '0;
         r_rem  <= '0;
         r_dbz  <= 1'b0;
      end else if (w_accept) begin
         r_dvr <= divisor;
         r_p   <= '0;
         r_q   <= dividend;
         r_cnt <= CNT_LAST;
         if (w_dvr_zero) begin
            r_quot <= '1;
            r_rem  <= '0;
            r_dbz  <= 1'b1;
         end
      end else if (r_state == S_RUN) begin
         r_p   <= w_p_new;
         r_q   <= w_q_new;
         r_cnt <= r_cnt - CNT_W'(1);
         if (w_last) begin
            r_quot <= w_q_new;
            r_rem  <= w_p_new[DVR_W-1:0];
            r_dbz  <= 1'b0;
         end
      end
   end

   assign busy        = (r_state == S_RUN);
   assign done        = (r_state == S_DONE);
   assign quotient    = r_quot;
   assign remainder   = r_rem;
   assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_restoring_divider.sv
//------------------------------------------------------------------------------
// tb_seq_restoring_divider
//
// Self-checking bench for seq_restoring_divider (DVD_W=8, DVR_W=4). Expected
// results come from plain integer division in the bench; the multiply-back
// identity and handshake timing are checked for every operation.
//------------------------------------------------------------------------------
module tb_seq_restoring_divider;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b1;
   logic       start    = 1'b0;
   logic [7:0] dividend = 8'd0;
   logic [3:0] divisor  = 4'd0;
   logic       busy;
   logic       done;
   logic [7:0] quotient;
   logic [3:0] remainder;
   logic       div_by_zero;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   seq_restoring_divider #(
      .DVD_W(8),
      .DVR_W(4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .dividend   (dividend),
      .divisor    (divisor),
      .busy       (busy),
      .done       (done),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   // Drive a start request from the current (non-edge) time; returns 1ns
   // after the accepting edge with start dropped and operands scrambled.
   task automatic issue(input logic [7:0] a, input logic [3:0] b);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk);
      #1;
      start    = 1'b0;
      dividend = 8'($urandom);
      divisor  = 4'($urandom);
   endtask

   // Follow an issued operation up to its done cycle (returns at that
   // cycle's falling edge). poke>0 drives an extra 50/5 start request at that
   // cycle, which must be ignored because the divider is busy.
   task automatic wait_result(input logic [7:0] a, input logic [3:0] b, input int poke);
      int         lat;
      int         busy_cnt;
      logic       ez;
      logic [7:0] eq;
      logic [3:0] er;
      int         exp_lat;
      int         exp_busy;
      string      id;
      lat      = 0;
      busy_cnt = 0;
      ez       = (b == 4'd0);
      eq       = ez ? 8'hFF : 8'(int'(a) / int'(b));
      er       = ez ? 4'd0  : 4'(int'(a) % int'(b));
      exp_lat  = ez ? 1 : 9;
      exp_busy = ez ? 0 : 8;
      id       = $sformatf("%0d/%0d", a, b);
      for (int i = 1; i <= 30 && lat == 0; i++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (done) lat = i;
         if (poke > 0 && i == poke) begin
            start    = 1'b1;
            dividend = 8'd50;
            divisor  = 4'd5;
         end
         if (poke > 0 && i == poke + 1) begin
            start    = 1'b0;
            dividend = 8'($urandom);
            divisor  = 4'($urandom);
         end
      end
      chk({id, " done_latency"}, 32'(lat), 32'(exp_lat));
      chk({id, " busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
      chk({id, " busy_in_done"}, 32'(busy), 32'd0);
      chk({id, " quotient"}, 32'(quotient), 32'(eq));
      chk({id, " remainder"}, 32'(remainder), 32'(er));
      chk({id, " div_by_zero"}, 32'(div_by_zero), 32'(ez));
      if (!ez) begin
         chk({id, " q*d+r"}, 32'(int'(quotient) * int'(b) + int'(remainder)), 32'(a));
         chk({id, " r_lt_d"}, 32'(remainder < b), 32'd1);
      end
      $display("op %0d/%0d -> q=%0d r=%0d dbz=%0d lat=%0d busy=%0d",
               a, b, quotient, remainder, div_by_zero, lat, busy_cnt);
   endtask

   task automatic run_op(input logic [7:0] a, input logic [3:0] b);
      @(negedge clk);
      issue(a, b);
      wait_result(a, b, 0);
   endtask

   initial begin
      int cnt;

      // Reset state
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset quotient", 32'(quotient), 32'd0);
      chk("reset remainder", 32'(remainder), 32'd0);
      chk("reset div_by_zero", 32'(div_by_zero), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed operations
      run_op(8'd200, 4'd7);
      run_op(8'd225, 4'd15);
      run_op(8'd5, 4'd9);
      run_op(8'd255, 4'd1);
      run_op(8'd0, 4'd6);
      run_op(8'd100, 4'd0);
      run_op(8'd100, 4'd3);

      // start while busy is ignored; exactly one done pulse
      @(negedge clk);
      issue(8'd200, 4'd7);
      wait_result(8'd200, 4'd7, 3);
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done) cnt++;
      end
      chk("ignored start extra done", 32'(cnt), 32'd0);
      $display("ignored start: extra done pulses=%0d", cnt);

      // Reset mid-operation aborts with no done afterwards
      @(negedge clk);
      issue(8'd9, 4'd2);
      repeat (3) @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort busy", 32'(busy), 32'd0);
      chk("abort done", 32'(done), 32'd0);
      chk("abort quotient", 32'(quotient), 32'd0);
      chk("abort remainder", 32'(remainder), 32'd0);
      chk("abort div_by_zero", 32'(div_by_zero), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done || busy) cnt++;
      end
      chk("abort no resume", 32'(cnt), 32'd0);
      $display("abort: busy/done cycles after release=%0d", cnt);
      run_op(8'd9, 4'd2);

      // Back-to-back: start in the done cycle of the previous op
      issue(8'd144, 4'd12);
      wait_result(8'd144, 4'd12, 0);
      issue(8'd100, 4'd0);
      wait_result(8'd100, 4'd0, 0);
      issue(8'd100, 4'd3);
      wait_result(8'd100, 4'd3, 0);

      // Full sweep of nonzero divisors
      for (int a = 0; a < 256; a++) begin
         for (int b = 1; b < 16; b++) begin
            run_op(8'(a), 4'(b));
         end
      end

      // Random operations, including zero divisors and back-to-back starts
      for (int k = 0; k < 200; k++) begin
         logic [7:0] ra;
         logic [3:0] rb;
         ra = 8'($urandom);
         rb = 4'($urandom);
         if ($urandom_range(0, 1) == 0) @(negedge clk);
         issue(ra, rb);
         wait_result(ra, rb, 0);
      end

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
